// File: rtl/xferdata_ctl_pkg.sv
// Shared definitions for the xferdata flow-control sequencer: state encoding,
// width helper and headroom limit generator.
package xferdata_ctl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    function automatic int unsigned width_of(input int unsigned msb);
        return msb + 1;
    endfunction

    // Largest occupancy the buffer can hold without wrapping its signed count.
    function automatic int unsigned head_limit(input int unsigned amsb);
        return (32'd1 << (amsb + 1)) - 1;
    endfunction

endpackage

// File: rtl/xferdata_ctl_oreg.sv
// Downstream holding register for xferdata_ctl: one word with valid/ready,
// reloadable in the same cycle the current word is accepted.
module xferdata_ctl_oreg
    import xferdata_ctl_pkg::*;
#(
    parameter int TMSB = 31
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          load,
    input  logic [TMSB:0] d,
    output logic [TMSB:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          free
);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            m_data  <= '0;
            m_valid <= 1'b0;
        end else if (load) begin
            m_data  <= d;
            m_valid <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    assign free = ~m_valid | m_ready;

endmodule

// File: rtl/xferdata_ctl.sv
// Flow-control sequencer between a narrow producer and the xferdata width
// converter buffer, with a registered downstream port and padded flush.
module xferdata_ctl
    import xferdata_ctl_pkg::*;
#(
    parameter int   RMSB = 7,
    parameter int   TMSB = 31,
    parameter int   AMSB = 6,
    parameter logic PAD  = 1'b1
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic [AMSB:0] cfg_rmsb,
    input  logic [AMSB:0] cfg_tmsb,
    input  logic          start,
    input  logic          flush,
    output logic          busy,
    input  logic [RMSB:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [RMSB:0] rx,
    output logic          re,
    output logic [AMSB:0] rmsb,
    output logic          te,
    output logic [AMSB:0] tmsb,
    input  logic [AMSB+1:0] cnt,
    input  logic [TMSB:0] tx,
    output logic [TMSB:0] m_data,
    output logic          m_valid,
    input  logic          m_ready
);

    // Headroom arithmetic is two bits wider than the count so sums never wrap.
    localparam int W = AMSB + 3;
    localparam logic [W-1:0] LIMIT = W'(head_limit(AMSB));

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [AMSB:0] rmsb_q;
    logic [AMSB:0] tmsb_q;
    logic [W-1:0]  rwd;
    logic [W-1:0]  twd;
    logic [W-1:0]  cnt_pos;
    logic [W-1:0]  cnt_eff;
    logic          room;
    logic          pad_need;
    logic          free;
    logic          te_i;
    logic          re_i;
    logic          s_ready_i;
    logic [RMSB:0] rx_i;

    assign cnt_pos = cnt[AMSB+1] ? '0 : {2'b00, cnt[AMSB:0]};

    always_comb begin
        rwd       = W'(width_of(32'(rmsb_q)));
        twd       = W'(width_of(32'(tmsb_q)));
        te_i      = rstb & (state_q != ST_IDLE) & (cnt_pos >= twd) & free;
        cnt_eff   = te_i ? (cnt_pos - twd) : cnt_pos;
        room      = (cnt_eff + rwd) <= LIMIT;
        pad_need  = (cnt_pos != '0) & (cnt_pos < twd);
        s_ready_i = 1'b0;
        re_i      = 1'b0;
        rx_i      = s_data;
        state_d   = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                s_ready_i = room;
                re_i      = s_valid & room;
                if (flush) state_d = ST_FLUSH;
            end
            // Pad a partial tail up to one full output word, then drain.
            ST_FLUSH: begin
                rx_i = {(RMSB+1){PAD}};
                if (pad_need) re_i = room;
                else          state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((cnt_pos < twd) && !m_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            rmsb_q  <= '0;
            tmsb_q  <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && start) begin
                rmsb_q <= cfg_rmsb;
                tmsb_q <= cfg_tmsb;
            end
        end
    end

    assign te      = te_i;
    assign re      = rstb & re_i;
    assign s_ready = rstb & s_ready_i;
    assign rx      = rx_i;
    assign rmsb    = rmsb_q;
    assign tmsb    = tmsb_q;
    assign busy    = (state_q != ST_IDLE);

    xferdata_ctl_oreg #(
        .TMSB(TMSB)
    ) u_oreg (
        .clk     (clk),
        .rstb    (rstb),
        .load    (te_i),
        .d       (tx),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .free    (free)
    );

endmodule

// File: tb/tb_xferdata_ctl.sv
// Bench for xferdata_ctl: bit-level buffer model plus an output scoreboard
// fed with hand-computed words and drained by an independent monitor.
module tb_xferdata_ctl;

    logic              clk = 1'b0;
    logic              rstb;
    logic [6:0]        cfg_rmsb;
    logic [6:0]        cfg_tmsb;
    logic              start;
    logic              flush;
    logic              busy;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        rx;
    logic              re;
    logic [6:0]        rmsb;
    logic              te;
    logic [6:0]        tmsb;
    logic signed [7:0] cnt;
    logic [31:0]       tx;
    logic [31:0]       m_data;
    logic              m_valid;
    logic              m_ready;

    int total = 0;
    int bad   = 0;
    logic [31:0] expq[$];

    logic [255:0] bufv;
    int           bcnt;
    int           re_n, te_n, pad_n, max_cnt, min_cnt;
    logic         pre_en;
    logic [255:0] pre_bits;
    int           pre_n;

    always #5 clk = ~clk;

    xferdata_ctl dut (
        .clk      (clk),
        .rstb     (rstb),
        .cfg_rmsb (cfg_rmsb),
        .cfg_tmsb (cfg_tmsb),
        .start    (start),
        .flush    (flush),
        .busy     (busy),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .rx       (rx),
        .re       (re),
        .rmsb     (rmsb),
        .te       (te),
        .tmsb     (tmsb),
        .cnt      (cnt),
        .tx       (tx),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    assign cnt = 8'(bcnt);
    assign tx  = bufv[31:0];

    // Buffer model: bits packed LSB-first, read pops before write pushes.
    always @(posedge clk) begin
        logic [255:0] nv;
        int nc;
        int rw;
        if (!rstb) begin
            bufv    <= '0;
            bcnt    <= 0;
            re_n    = 0;
            te_n    = 0;
            pad_n   = 0;
            max_cnt = 0;
            min_cnt = 0;
        end else begin
            nv = bufv;
            nc = bcnt;
            if (pre_en) begin
                nv = pre_bits;
                nc = pre_n;
            end
            if (te) begin
                nv = nv >> (int'(tmsb) + 1);
                nc = nc - (int'(tmsb) + 1);
                te_n++;
            end
            if (re) begin
                rw = int'(rmsb) + 1;
                nv = nv | ((256'(rx) & ((256'd1 << rw) - 256'd1)) << nc);
                nc = nc + rw;
                re_n++;
                if (!s_ready) pad_n++;
            end
            if (nc > max_cnt) max_cnt = nc;
            if (nc < min_cnt) min_cnt = nc;
            bufv <= nv;
            bcnt <= nc;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted downstream beat must match the next queued word.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rstb && m_valid && m_ready) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_beat: got m_data=0x%08h required no beat", m_data);
            end else begin
                e = expq.pop_front();
                checkOutput("m_data_beat", 64'(m_data), 64'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstb    = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        tick();
        tick();
        rstb = 1'b1;
    endtask

    task automatic preload(input logic [255:0] bits, input int n);
        pre_bits = bits;
        pre_n    = n;
        pre_en   = 1'b1;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic startRun(input logic [6:0] rm, input logic [6:0] tm);
        cfg_rmsb = rm;
        cfg_tmsb = tm;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Offer one upstream word; handshake completes at the edge after s_ready is seen.
    task automatic applyStimulus(input logic [7:0] d, input int budget, output bit ok);
        s_data  = d;
        s_valid = 1'b1;
        ok      = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) tick();
        s_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, 64'(seen), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish required finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit ok;
        int accepted;
        rstb     = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        cfg_rmsb = 7'd7;
        cfg_tmsb = 7'd31;
        s_data   = '0;
        s_valid  = 1'b0;
        m_ready  = 1'b0;
        pre_en   = 1'b0;
        pre_bits = '0;
        pre_n    = 0;
        tick();
        tick();
        @(negedge clk);
        checkOutput("reset_busy",    64'(busy),    64'd0);
        checkOutput("reset_s_ready", 64'(s_ready), 64'd0);
        checkOutput("reset_m_valid", 64'(m_valid), 64'd0);
        checkOutput("reset_m_data",  64'(m_data),  64'd0);
        checkOutput("reset_rmsb",    64'(rmsb),    64'd0);
        checkOutput("reset_te_re",   64'({te, re}), 64'd0);

        // Four bytes make one 32-bit word, delivered for exactly one cycle.
        doReset();
        m_ready = 1'b1;
        startRun(7'd7, 7'd31);
        expq.push_back(32'h44332211);
        applyStimulus(8'h11, 10, ok);
        applyStimulus(8'h22, 10, ok);
        applyStimulus(8'h33, 10, ok);
        applyStimulus(8'h44, 10, ok);
        @(negedge clk);
        checkOutput("te_at_32",        64'(te),      64'd1);
        checkOutput("m_valid_before",  64'(m_valid), 64'd0);
        @(negedge clk);
        checkOutput("m_valid_pulse",   64'(m_valid), 64'd1);
        @(negedge clk);
        checkOutput("m_valid_one_cyc", 64'(m_valid), 64'd0);

        // Output stalled with 64 bits buffered, then released: three beats, no bubble.
        doReset();
        m_ready = 1'b0;
        startRun(7'd7, 7'd31);
        expq.push_back(32'h04030201);
        expq.push_back(32'h08070605);
        expq.push_back(32'h0C0B0A09);
        for (int i = 1; i <= 12; i++) applyStimulus(8'(i), 10, ok);
        @(negedge clk);
        checkOutput("stall_te",      64'(te),      64'd0);
        checkOutput("stall_m_valid", 64'(m_valid), 64'd1);
        checkOutput("stall_cnt",     64'(bcnt),    64'd64);
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_te", 64'(te), 64'd1);
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            checkOutput("b2b_valid", 64'(m_valid), 64'd1);
        end
        @(negedge clk);
        checkOutput("b2b_end", 64'(m_valid), 64'd0);

        // Backpressure: headroom stops intake at 120 bits; then reset mid-run.
        doReset();
        m_ready = 1'b0;
        startRun(7'd7, 7'd31);
        accepted = 0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(8'(i), 10, ok);
            if (ok) accepted++;
        end
        @(negedge clk);
        checkOutput("bp_accepted", 64'(accepted),       64'd19);
        checkOutput("bp_s_ready",  64'(s_ready),        64'd0);
        checkOutput("bp_max_cnt",  64'(max_cnt),        64'd120);
        checkOutput("bp_no_neg",   64'(min_cnt < 0),    64'd0);
        checkOutput("bp_m_valid",  64'(m_valid),        64'd1);
        tick();
        rstb    = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst_te_re_gated", 64'({te, re, s_ready}), 64'd0);
        @(negedge clk);
        checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
        checkOutput("rst_busy",    64'(busy),    64'd0);
        checkOutput("rst_s_ready", 64'(s_ready), 64'd0);
        tick();
        rstb = 1'b1;
        for (int i = 0; i < 20; i++) tick();

        // Flush from a 12-bit tail: three pad writes, one word, 4 bits left.
        doReset();
        m_ready = 1'b1;
        preload(256'hABC, 12);
        startRun(7'd7, 7'd31);
        expq.push_back(32'hFFFFFABC);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_s_ready", 64'(s_ready), 64'd0);
        checkOutput("flush_re",      64'(re),      64'd1);
        checkOutput("flush_rx",      64'(rx),      64'hFF);
        waitIdle("flush_idle", 20);
        checkOutput("flush_pads", 64'(pad_n), 64'd3);
        checkOutput("flush_te",   64'(te_n),  64'd1);
        checkOutput("flush_cnt",  64'(bcnt),  64'd4);

        // Empty flush, plus start while busy and flush in IDLE ignored.
        doReset();
        m_ready = 1'b1;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        @(negedge clk);
        checkOutput("idle_flush_busy", 64'(busy), 64'd0);
        startRun(7'd7, 7'd31);
        startRun(7'd3, 7'd15);
        @(negedge clk);
        checkOutput("busy_start_rmsb", 64'(rmsb), 64'd7);
        checkOutput("busy_start_tmsb", 64'(tmsb), 64'd31);
        checkOutput("busy_run",        64'(busy), 64'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        waitIdle("empty_flush_idle", 10);
        checkOutput("empty_flush_te", 64'(te_n), 64'd0);
        checkOutput("empty_flush_re", 64'(re_n), 64'd0);

        for (int i = 0; i < 4; i++) tick();
        checkOutput("scoreboard_empty", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
